// File: rtl/butterfly_pipe.sv
// Radix-2 FFT butterfly, three register stages:
//   S1 operand capture, S2 full-precision products, S3 rounded/saturated results.
// The whole pipe advances on one global enable, which gives full backpressure
// without skid buffers. ovf is sticky and records any clamped output component.
module butterfly_pipe #(
  parameter int WIDTH   = 16,
  parameter int TW_FRAC = WIDTH/2 - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [WIDTH-1:0] twiddle,
  input  logic             inverse,
  input  logic             scale,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output1,
  output logic [WIDTH-1:0] output2,
  output logic             ovf,
  input  logic             ovf_clear
);

  localparam int H  = WIDTH/2;
  localparam int PW = 2*H;      // one B*W partial product
  localparam int TW = 2*H + 2;  // sum of two products plus rounding headroom
  localparam int RW = H + 2;    // rounded term and A +/- term

  localparam logic signed [H-1:0]  S_MAX = {1'b0, {(H-1){1'b1}}};
  localparam logic signed [H-1:0]  S_MIN = {1'b1, {(H-1){1'b0}}};
  localparam logic signed [TW-1:0] RND   = TW'(1) << (TW_FRAC-1);

  logic en;

  // S1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s1_w_q, s1_w_d;
  logic             s1_inv_q, s1_inv_d;
  logic             s1_scale_q, s1_scale_d;

  // S2 registers
  logic                 s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]     s2_a_q, s2_a_d;
  logic                 s2_scale_q, s2_scale_d;
  logic signed [PW-1:0] s2_p_rr_q, s2_p_rr_d;
  logic signed [PW-1:0] s2_p_ii_q, s2_p_ii_d;
  logic signed [PW-1:0] s2_p_ri_q, s2_p_ri_d;
  logic signed [PW-1:0] s2_p_ir_q, s2_p_ir_d;

  // S3 registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic             ovf_q, ovf_d;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign output1   = out1_q;
  assign output2   = out2_q;
  assign ovf       = ovf_q;

  // Clamp to H bits; the MSB of the result flags that clamping happened.
  function automatic logic [H:0] sat(input logic signed [RW-1:0] x);
    if (x > RW'(S_MAX))      sat = {1'b1, S_MAX};
    else if (x < RW'(S_MIN)) sat = {1'b1, S_MIN};
    else                     sat = {1'b0, x[H-1:0]};
  endfunction

  // S1 next state: capture the incoming beat when the pipe advances
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_w_d     = s1_w_q;
    s1_inv_d   = s1_inv_q;
    s1_scale_d = s1_scale_q;
    if (en) begin
      s1_valid_d = in_valid;
      s1_a_d     = input1;
      s1_b_d     = input2;
      s1_w_d     = twiddle;
      s1_inv_d   = inverse;
      s1_scale_d = scale;
    end
  end

  logic signed [H-1:0] b_re, b_im, w_re, w_im, w_im_c;
  assign b_re = s1_b_q[H-1:0];
  assign b_im = s1_b_q[WIDTH-1:H];
  assign w_re = s1_w_q[H-1:0];
  assign w_im = s1_w_q[WIDTH-1:H];

  // S2 next state: conjugate the twiddle if asked, then form the four products
  always_comb begin
    w_im_c = w_im;
    if (s1_inv_q) w_im_c = (w_im == S_MIN) ? S_MAX : -w_im;
    s2_valid_d = s2_valid_q;
    s2_a_d     = s2_a_q;
    s2_scale_d = s2_scale_q;
    s2_p_rr_d  = s2_p_rr_q;
    s2_p_ii_d  = s2_p_ii_q;
    s2_p_ri_d  = s2_p_ri_q;
    s2_p_ir_d  = s2_p_ir_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_a_d     = s1_a_q;
      s2_scale_d = s1_scale_q;
      s2_p_rr_d  = PW'(b_re) * PW'(w_re);
      s2_p_ii_d  = PW'(b_im) * PW'(w_im_c);
      s2_p_ri_d  = PW'(b_re) * PW'(w_im_c);
      s2_p_ir_d  = PW'(b_im) * PW'(w_re);
    end
  end

  // index 0 = real, 1 = imaginary
  logic signed [H-1:0]  a2    [2];
  logic signed [TW-1:0] t_full[2];
  logic signed [TW-1:0] t_rnd [2];
  logic signed [RW-1:0] t_r   [2];
  logic signed [RW-1:0] s_v   [2];
  logic signed [RW-1:0] d_v   [2];
  logic [H:0]           s_sat [2];
  logic [H:0]           d_sat [2];

  // Combine products, round half-up, form A +/- t, optional halving, saturate
  always_comb begin
    t_full[0] = TW'(s2_p_rr_q) - TW'(s2_p_ii_q);
    t_full[1] = TW'(s2_p_ri_q) + TW'(s2_p_ir_q);
    for (int k = 0; k < 2; k++) begin
      a2[k]    = s2_a_q[k*H +: H];
      t_rnd[k] = t_full[k] + RND;
      t_r[k]   = t_rnd[k][RW+TW_FRAC-1:TW_FRAC];
      s_v[k]   = RW'(a2[k]) + t_r[k];
      d_v[k]   = RW'(a2[k]) - t_r[k];
      if (s2_scale_q) begin
        s_v[k] = s_v[k] >>> 1;
        d_v[k] = d_v[k] >>> 1;
      end
      s_sat[k] = sat(s_v[k]);
      d_sat[k] = sat(d_v[k]);
    end
  end

  // S3 next state: load results; sticky overflow where a set beats a clear
  always_comb begin
    out_valid_d = out_valid_q;
    out1_d      = out1_q;
    out2_d      = out2_q;
    ovf_d       = ovf_q & ~ovf_clear;
    if (en) begin
      out_valid_d = s2_valid_q;
      out1_d      = {s_sat[1][H-1:0], s_sat[0][H-1:0]};
      out2_d      = {d_sat[1][H-1:0], d_sat[0][H-1:0]};
      if (s2_valid_q && (s_sat[0][H] || s_sat[1][H] || d_sat[0][H] || d_sat[1][H]))
        ovf_d = 1'b1;
    end
  end

  // All pipeline registers; reset discards in-flight beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_w_q      <= '0;
      s1_inv_q    <= 1'b0;
      s1_scale_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_a_q      <= '0;
      s2_scale_q  <= 1'b0;
      s2_p_rr_q   <= '0;
      s2_p_ii_q   <= '0;
      s2_p_ri_q   <= '0;
      s2_p_ir_q   <= '0;
      out_valid_q <= 1'b0;
      out1_q      <= '0;
      out2_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_w_q      <= s1_w_d;
      s1_inv_q    <= s1_inv_d;
      s1_scale_q  <= s1_scale_d;
      s2_valid_q  <= s2_valid_d;
      s2_a_q      <= s2_a_d;
      s2_scale_q  <= s2_scale_d;
      s2_p_rr_q   <= s2_p_rr_d;
      s2_p_ii_q   <= s2_p_ii_d;
      s2_p_ri_q   <= s2_p_ri_d;
      s2_p_ir_q   <= s2_p_ir_d;
      out_valid_q <= out_valid_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule
